mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter for instruction fetch and data access
// Data has priority, bounded by a streak limit; a no-ack watchdog latches a sticky error.
module mem_arbiter #(
   parameter int unsigned DSTREAK_MAX = 4,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        ihit,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dhit,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramACK,
   output logic        busy,
   output logic        timeout_err
);

   localparam int DSW = $clog2(DSTREAK_MAX + 1);
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [DSW-1:0] DS_LIMIT = DSW'(DSTREAK_MAX);
   localparam logic [DSW-1:0] DS_ONE   = DSW'(1);
   localparam logic [WDW-1:0] WD_ONE   = WDW'(1);

   typedef enum logic [2:0] {IDLE, IACC, DACC, RESP, ERR} state_t;

   state_t         state;
   state_t         state_next;
   logic [DSW-1:0] dstreak;
   logic [WDW-1:0] wd_cnt;
   logic           wr_q;
   logic           data_side;
   logic           in_access;
   logic           grant_d;
   logic           grant_i;
   logic           wd_expire;

   assign in_access = (state == IACC) || (state == DACC);

   // A pending fetch only overrides data once the data streak has hit its limit.
   assign grant_d = (dREN | dWEN) & ~(iREN & (dstreak == DS_LIMIT));
   assign grant_i = ~grant_d & iREN;

   assign wd_expire = (TIMEOUT != 0) && in_access && !ramACK &&
                      ((32'(wd_cnt) + 32'd1) == TIMEOUT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_next = DACC;
            end else if (grant_i) begin
               state_next = IACC;
            end
         end
         IACC, DACC: begin
            if (ramACK) begin
               state_next = RESP;
            end else if (wd_expire) begin
               state_next = ERR;
            end
         end
         RESP:    state_next = IDLE;
         ERR:     state_next = ERR;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dstreak     <= '0;
         wd_cnt      <= '0;
         wr_q        <= 1'b0;
         data_side   <= 1'b0;
         ramaddr     <= '0;
         ramstore    <= '0;
         iload       <= '0;
         dload       <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE) begin
            wd_cnt <= '0;
            if (grant_d) begin
               ramaddr   <= {daddr[31:2], 2'b00};
               ramstore  <= dstore;
               wr_q      <= dWEN;
               data_side <= 1'b1;
               if (!iREN) begin
                  dstreak <= '0;
               end else if (dstreak != DS_LIMIT) begin
                  dstreak <= dstreak + DS_ONE;
               end
            end else if (grant_i) begin
               ramaddr   <= {iaddr[31:2], 2'b00};
               wr_q      <= 1'b0;
               data_side <= 1'b0;
               dstreak   <= '0;
            end
         end

         // Writes leave dload untouched so the data side keeps its last read value.
         if (in_access) begin
            if (ramACK) begin
               if (state == IACC) begin
                  iload <= ramload;
               end else if (!wr_q) begin
                  dload <= ramload;
               end
            end else begin
               wd_cnt <= wd_cnt + WD_ONE;
            end
         end

         if (wd_expire) begin
            timeout_err <= 1'b1;
         end
      end
   end

   assign ramREN = (state == IACC) || ((state == DACC) && !wr_q);
   assign ramWEN = (state == DACC) && wr_q;
   assign ihit   = (state == RESP) && !data_side;
   assign dhit   = (state == RESP) && data_side;
   assign busy   = in_access || (state == RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
// Per-cycle table of inputs and expected outputs, plus hand-written watchdog sequence.
module tb_mem_arbiter;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        ihit;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dhit;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ramACK;
   logic        busy;
   logic        timeout_err;

   mem_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramACK(ramACK),
      .busy(busy), .timeout_err(timeout_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ctl bits: {ihit, dhit, ramREN, ramWEN, busy, timeout_err}
   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_RD   = 6'b001010;
   localparam logic [5:0] C_WR   = 6'b000110;
   localparam logic [5:0] C_IHIT = 6'b100010;
   localparam logic [5:0] C_DHIT = 6'b010010;
   localparam logic [5:0] C_ERR  = 6'b000001;

   typedef struct packed {
      logic        rst, iren, dren, dwen, ack;
      logic [31:0] ia, da, ds, rl;
      logic [5:0]  ctl;
      logic        c_addr, c_store, c_iload, c_dload;
      logic [31:0] e_addr, e_store, e_iload, e_dload;
   } vec_t;

   vec_t vecs[$];
   int   last;
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input logic rst, iren, dren, dwen, ack,
                      input logic [31:0] ia, da, ds, rl, input logic [5:0] ctl);
      vec_t r;
      r = '0;
      r.rst = rst; r.iren = iren; r.dren = dren; r.dwen = dwen; r.ack = ack;
      r.ia = ia; r.da = da; r.ds = ds; r.rl = rl; r.ctl = ctl;
      vecs.push_back(r);
      last = vecs.size() - 1;
   endtask

   task automatic exp_addr(input logic [31:0] v);
      vecs[last].c_addr = 1'b1; vecs[last].e_addr = v;
   endtask
   task automatic exp_store(input logic [31:0] v);
      vecs[last].c_store = 1'b1; vecs[last].e_store = v;
   endtask
   task automatic exp_iload(input logic [31:0] v);
      vecs[last].c_iload = 1'b1; vecs[last].e_iload = v;
   endtask
   task automatic exp_dload(input logic [31:0] v);
      vecs[last].c_dload = 1'b1; vecs[last].e_dload = v;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ctl_now();
      return {26'd0, ihit, dhit, ramREN, ramWEN, busy, timeout_err};
   endfunction

   bit          is_d[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   logic [31:0] v;
   int          n;
   logic        ok;

   initial begin
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramACK = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

      // single fetch
      add(0,1,0,0,0, 32'h104,0,0,0, C_IDLE);
      add(0,1,0,0,1, 32'h104,0,0,32'hDEADBEEF, C_RD); exp_addr(32'h104);
      add(0,1,0,0,0, 32'h104,0,0,0, C_IHIT); exp_iload(32'hDEADBEEF);
      add(0,0,0,0,0, 0,0,0,0, C_IDLE);
      // simultaneous fetch and write: data first
      add(0,1,0,1,0, 32'h200,32'h20,32'h5A,0, C_IDLE);
      add(0,1,0,1,1, 32'h200,32'h20,32'h5A,0, C_WR); exp_addr(32'h20); exp_store(32'h5A);
      add(0,1,0,1,0, 32'h200,32'h20,32'h5A,0, C_DHIT); exp_dload(32'h0);
      add(0,1,0,0,0, 32'h200,0,0,0, C_IDLE);
      add(0,1,0,0,1, 32'h200,0,0,32'h11111111, C_RD); exp_addr(32'h200);
      add(0,1,0,0,0, 32'h200,0,0,0, C_IHIT); exp_iload(32'h11111111);
      add(0,0,0,0,0, 0,0,0,0, C_IDLE);
      // misaligned read, 3 wait states, daddr changes mid-access
      add(0,0,1,0,0, 0,32'h23,0,0, C_IDLE);
      add(0,0,1,0,0, 0,32'h23,0,0, C_RD); exp_addr(32'h20);
      add(0,0,1,0,0, 0,32'h40,0,0, C_RD); exp_addr(32'h20);
      add(0,0,1,0,0, 0,32'h40,0,0, C_RD); exp_addr(32'h20);
      add(0,0,1,0,1, 0,32'h40,0,32'hCAFEF00D, C_RD); exp_addr(32'h20);
      add(0,0,1,0,0, 0,32'h40,0,0, C_DHIT); exp_dload(32'hCAFEF00D);
      add(0,0,0,0,1, 0,0,0,32'h99999999, C_IDLE);
      add(0,0,0,0,0, 0,0,0,0, C_IDLE); exp_dload(32'hCAFEF00D);
      // starvation bound: four data grants, then one fetch, repeated
      for (int k = 0; k < 10; k++) begin
         v = 32'hA0000000 + 32'(k);
         add(0,1,1,0,0, 32'h300,32'h404,0,0, C_IDLE);
         add(0,1,1,0,1, 32'h300,32'h404,0,v, C_RD);
         exp_addr(is_d[k] ? 32'h404 : 32'h300);
         add(0,1,1,0,0, 32'h300,32'h404,0,0, is_d[k] ? C_DHIT : C_IHIT);
         if (is_d[k]) exp_dload(v); else exp_iload(v);
      end
      add(0,0,0,0,0, 0,0,0,0, C_IDLE);
      // reset in second access cycle, coinciding with ack; later ack ignored
      add(0,0,1,0,0, 0,32'h50,0,0, C_IDLE);
      add(0,0,1,0,0, 0,32'h50,0,0, C_RD); exp_addr(32'h50);
      add(1,0,1,0,1, 0,32'h50,0,32'h77777777, C_RD); exp_addr(32'h50);
      add(0,0,0,0,1, 0,0,0,32'h88888888, C_IDLE);
      exp_addr(0); exp_store(0); exp_iload(0); exp_dload(0);
      add(0,0,0,0,0, 0,0,0,0, C_IDLE); exp_dload(0);

      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      check("reset_ctl", ctl_now(), {26'd0, C_IDLE});
      check("reset_ramaddr", ramaddr, 32'h0);
      check("reset_ramstore", ramstore, 32'h0);
      check("reset_iload", iload, 32'h0);
      check("reset_dload", dload, 32'h0);

      foreach (vecs[i]) begin
         RST = vecs[i].rst; iREN = vecs[i].iren; dREN = vecs[i].dren;
         dWEN = vecs[i].dwen; ramACK = vecs[i].ack; iaddr = vecs[i].ia;
         daddr = vecs[i].da; dstore = vecs[i].ds; ramload = vecs[i].rl;
         @(negedge CLK);
         check($sformatf("row%0d_ctl", i), ctl_now(), {26'd0, vecs[i].ctl});
         if (vecs[i].c_addr)  check($sformatf("row%0d_ramaddr", i), ramaddr, vecs[i].e_addr);
         if (vecs[i].c_store) check($sformatf("row%0d_ramstore", i), ramstore, vecs[i].e_store);
         if (vecs[i].c_iload) check($sformatf("row%0d_iload", i), iload, vecs[i].e_iload);
         if (vecs[i].c_dload) check($sformatf("row%0d_dload", i), dload, vecs[i].e_dload);
         @(posedge CLK);
         #1;
      end

      // watchdog: fetch with no ack, error expected in cycle t+9
      RST = 0; dREN = 0; dWEN = 0; ramACK = 0; iREN = 1; iaddr = 32'h600;
      n = 0; ok = 1'b1;
      while (!timeout_err && n < 20) begin
         @(posedge CLK);
         #1;
         n++;
         if (!timeout_err && !(ramREN && busy && ramaddr == 32'h600)) ok = 1'b0;
      end
      check("wd_cycles_to_err", 32'(n), 32'd9);
      check("wd_strobe_held", {31'd0, ok}, 32'd1);
      check("wd_err_ctl", ctl_now(), {26'd0, C_ERR});

      dREN = 1; ramACK = 1; ok = 1'b1;
      repeat (4) begin
         @(posedge CLK);
         #1;
         if (ctl_now() != {26'd0, C_ERR}) ok = 1'b0;
      end
      check("wd_err_sticky", {31'd0, ok}, 32'd1);

      RST = 1; dREN = 0; ramACK = 0; iREN = 0;
      @(posedge CLK);
      #1;
      RST = 0;
      check("wd_rst_clears", ctl_now(), {26'd0, C_IDLE});
      iREN = 1; iaddr = 32'h700;
      @(posedge CLK);
      #1;
      check("wd_recover_ctl", ctl_now(), {26'd0, C_RD});
      check("wd_recover_addr", ramaddr, 32'h700);
      ramACK = 1; ramload = 32'h12345678;
      @(posedge CLK);
      #1;
      ramACK = 0;
      check("wd_recover_hit", ctl_now(), {26'd0, C_IHIT});
      check("wd_recover_iload", iload, 32'h12345678);
      iREN = 0;
      @(posedge CLK);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
